// File: rtl/dnoc_itf_pkg.sv
// Shared types and defaults for the dNoC interface ping-pong buffer
// (write controller, read controller and state tracker).
package dnoc_itf_pkg;

    localparam int unsigned DNOC_DATA_W = 128;
    localparam int unsigned DNOC_DEPTH  = 256;

    typedef enum logic {
        FILL   = 1'b0,
        COMMIT = 1'b1
    } pp_wr_state_e;

    typedef logic bank_t;

endpackage

// File: rtl/dnoc_itf_pp_wr_ctrl.sv
// Ping-pong buffer write controller: accepts a valid/ready stream, fills the
// current bank and pulses pingpong_wr_done when the bank is committed.
module dnoc_itf_pp_wr_ctrl
    import dnoc_itf_pkg::*;
#(
    parameter int unsigned DATA_W = DNOC_DATA_W,
    parameter int unsigned DEPTH  = DNOC_DEPTH,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1,
    parameter int unsigned ADDR_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [1:0]        pingpong_state,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic              pingpong_wr_done,
    output logic [CNT_W-1:0]  wr_len,
    output bank_t             wr_bank
);

    localparam int unsigned IDX_W = ADDR_W - 1;

    pp_wr_state_e     state;
    pp_wr_state_e     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cfg_dec;
    logic [CNT_W-1:0] eff_len;
    logic             hs;
    logic             is_final;

    // Stream is stalled during the commit bubble and while the target bank is unread.
    assign in_ready = (state == FILL) && !pingpong_state[wr_bank];
    assign hs       = in_valid && in_ready;

    // First word of a bank sees the live length; later words use the latched one.
    assign cfg_dec  = (cfg_len == '0) ? CNT_W'(DEPTH) : cfg_len;
    assign eff_len  = (cnt == '0) ? cfg_dec : len_q;
    assign is_final = hs && ((cnt == (eff_len - CNT_W'(1))) || in_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (is_final) state_nxt = COMMIT;
            COMMIT:  state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Write port, word counter, length latch and bank pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_wr_en        <= 1'b0;
            buf_wr_addr      <= '0;
            buf_wr_data      <= '0;
            pingpong_wr_done <= 1'b0;
            wr_len           <= '0;
            wr_bank          <= 1'b0;
            cnt              <= '0;
            len_q            <= '0;
        end else begin
            buf_wr_en        <= hs;
            pingpong_wr_done <= is_final;
            if (hs) begin
                buf_wr_addr <= {wr_bank, cnt[IDX_W-1:0]};
                buf_wr_data <= in_data;
                cnt         <= cnt + CNT_W'(1);
                if (cnt == '0) begin
                    len_q <= cfg_dec;
                end
            end
            if (is_final) begin
                wr_len <= cnt + CNT_W'(1);
            end
            // The tracker toggles its write pointer on the same commit.
            if (state == COMMIT) begin
                wr_bank <= ~wr_bank;
                cnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dnoc_itf_pp_wr_ctrl.sv
// Self-checking bench for dnoc_itf_pp_wr_ctrl with a bank-level reference
// model and a behavioural ping-pong tracker.
module tb_dnoc_itf_pp_wr_ctrl;
    import dnoc_itf_pkg::*;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [CNT_W-1:0]  cfg_len = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [1:0]        pingpong_state = 2'b00;
    logic              buf_wr_en;
    logic [ADDR_W-1:0] buf_wr_addr;
    logic [DATA_W-1:0] buf_wr_data;
    logic              pingpong_wr_done;
    logic [CNT_W-1:0]  wr_len;
    bank_t             wr_bank;

    always #5 clk = ~clk;

    dnoc_itf_pp_wr_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .pingpong_state(pingpong_state),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .pingpong_wr_done(pingpong_wr_done), .wr_len(wr_len), .wr_bank(wr_bank)
    );

    int total = 0;
    int bad = 0;

    // Reference model: current bank, word index, bank length, commit bubble, tracker flags.
    int  m_bank = 0, m_idx = 0, m_len = 0, rptr = 0;
    bit  m_commit = 0, exp_ready = 0, rd_req = 0, auto_read = 0, accepted = 0;
    bit  full [2];
    bit  e_wen = 0, e_done = 0;
    int  e_addr = 0, e_len = 0;
    logic [DATA_W-1:0] e_data = '0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Advance one clock; update the model; check every output at negedge+1.
    task automatic tick();
        bit hs;
        bit fin;
        hs = in_valid && exp_ready;
        fin = 0;
        e_wen = hs;
        e_done = 0;
        if (hs) begin
            if (m_idx == 0) m_len = (cfg_len == '0) ? DEPTH : int'(cfg_len);
            e_addr = m_bank * DEPTH + m_idx;
            e_data = in_data;
            m_idx++;
            fin = in_last || (m_idx == m_len);
        end
        if (auto_read && (full[0] || full[1]) && $urandom_range(0, 2) == 0) rd_req = 1;
        @(posedge clk);
        if (rd_req && full[rptr]) begin
            full[rptr] = 0;
            rptr ^= 1;
        end
        if (m_commit) begin
            full[m_bank] = 1;
            m_bank ^= 1;
            m_idx = 0;
        end
        m_commit = fin;
        if (fin) begin
            e_done = 1;
            e_len = m_idx;
        end
        accepted = hs;
        @(negedge clk);
        pingpong_state = {full[1], full[0]};
        rd_req = 0;
        exp_ready = !m_commit && !full[m_bank];
        #1;
        check("in_ready", DATA_W'(in_ready), DATA_W'(exp_ready));
        check("buf_wr_en", DATA_W'(buf_wr_en), DATA_W'(e_wen));
        check("wr_done", DATA_W'(pingpong_wr_done), DATA_W'(e_done));
        check("wr_bank", DATA_W'(wr_bank), DATA_W'(m_bank));
        if (e_wen) begin
            check("buf_wr_addr", DATA_W'(buf_wr_addr), DATA_W'(e_addr));
            check("buf_wr_data", buf_wr_data, e_data);
        end
        if (e_done) check("wr_len", DATA_W'(wr_len), DATA_W'(e_len));
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input bit last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        accepted = 0;
        while (!accepted && n < 300) begin
            tick();
            n++;
        end
        check("accept_timeout", DATA_W'(accepted), DATA_W'(1));
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_wr_en", DATA_W'(buf_wr_en), DATA_W'(0));
        check("rst_wr_done", DATA_W'(pingpong_wr_done), DATA_W'(0));
        check("rst_wr_len", DATA_W'(wr_len), DATA_W'(0));
        check("rst_wr_addr", DATA_W'(buf_wr_addr), DATA_W'(0));
        check("rst_wr_data", buf_wr_data, DATA_W'(0));
        check("rst_wr_bank", DATA_W'(wr_bank), DATA_W'(0));
        in_valid = 1'b0;
        in_last = 1'b0;
        m_bank = 0; m_idx = 0; m_len = 0; rptr = 0; m_commit = 0;
        full[0] = 0; full[1] = 0; rd_req = 0;
        e_wen = 0; e_done = 0;
        pingpong_state = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        exp_ready = 1;
        #1;
    endtask

    initial begin
        full[0] = 0;
        full[1] = 0;

        // Test 1: four back-to-back words into bank 0.
        do_reset();
        cfg_len = CNT_W'(4);
        for (int i = 0; i < 4; i++) send(rnd_word(), 1'b0);
        check("t1_done", DATA_W'(pingpong_wr_done), DATA_W'(1));
        check("t1_len", DATA_W'(wr_len), DATA_W'(4));
        check("t1_addr", DATA_W'(buf_wr_addr), DATA_W'(3));
        idle(1);
        check("t1_bank", DATA_W'(wr_bank), DATA_W'(1));

        // Test 2: early commit via in_last on the third word, into bank 1.
        cfg_len = CNT_W'(8);
        send(rnd_word(), 1'b0);
        check("t2_first_addr", DATA_W'(buf_wr_addr), DATA_W'(DEPTH));
        send(rnd_word(), 1'b0);
        send(rnd_word(), 1'b1);
        check("t2_len", DATA_W'(wr_len), DATA_W'(3));
        idle(1);

        // Test 3: both banks full -> stall, then a read frees bank 0.
        in_valid = 1'b1;
        in_data = rnd_word();
        for (int i = 0; i < 20; i++) tick();
        check("t3_stall_ready", DATA_W'(in_ready), DATA_W'(0));
        rd_req = 1;
        send(in_data, 1'b0);
        check("t3_addr", DATA_W'(buf_wr_addr), DATA_W'(0));

        // Test 4: cfg_len 0 means a full DEPTH-word bank.
        do_reset();
        cfg_len = '0;
        for (int i = 0; i < int'(DEPTH); i++) send(rnd_word(), 1'b0);
        check("t4_addr", DATA_W'(buf_wr_addr), DATA_W'(DEPTH - 1));
        check("t4_len", DATA_W'(wr_len), DATA_W'(9'h100));
        idle(1);

        // Test 5: reset after two of four words discards the partial bank.
        do_reset();
        cfg_len = CNT_W'(4);
        send(rnd_word(), 1'b0);
        send(rnd_word(), 1'b0);
        do_reset();
        send(rnd_word(), 1'b0);
        check("t5_addr", DATA_W'(buf_wr_addr), DATA_W'(0));

        // Test 6: cfg_len change after the first handshake is ignored for this bank.
        cfg_len = CNT_W'(2);
        for (int i = 0; i < 3; i++) send(rnd_word(), 1'b0);
        check("t6_len4", DATA_W'(wr_len), DATA_W'(4));
        idle(1);
        send(rnd_word(), 1'b0);
        send(rnd_word(), 1'b0);
        check("t6_len2", DATA_W'(wr_len), DATA_W'(2));
        check("t6_addr", DATA_W'(buf_wr_addr), DATA_W'(DEPTH + 1));
        idle(1);

        // Random traffic: varying lengths, in_last, gaps and reader activity.
        do_reset();
        auto_read = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) cfg_len = CNT_W'($urandom_range(1, 6));
            send(rnd_word(), $urandom_range(0, 7) == 0);
            idle($urandom_range(0, 2));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
